// File: rtl/conv_chan_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_chan_mac
// Description : Multi-channel K x K convolution MAC. Each accepted beat carries
//               one K*K window for one input channel; CH_IN consecutive beats
//               are accumulated on top of a bias. The final sum is then
//               shifted, optionally ReLU-clamped, saturated to OUT_W and
//               presented on a valid/ready output. Weights live in an internal
//               runtime-writable array indexed ch*K*K + tap.
// Ports       : clk, rst_n (async assert, active-low)
//               flush                       - drop the partial accumulation
//               in_valid/in_ready/in_data   - window beat, tap 0 in LSBs
//               bias                        - sampled with the channel-0 beat
//               wgt_we/wgt_addr/wgt_data    - weight write port
//               out_valid/out_ready         - result handshake
//               out_data/out_sat            - result and clamp flag
// Revision    : 1.0 - initial release
// ============================================================================
module conv_chan_mac #(
  parameter int DATA_W = 12,
  parameter int WGT_W  = 8,
  parameter int K      = 3,
  parameter int CH_IN  = 3,
  parameter int ACC_W  = 24,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 14,
  parameter int RELU   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [K*K*DATA_W-1:0]         in_data,
  input  logic [ACC_W-1:0]              bias,
  input  logic                          wgt_we,
  input  logic [$clog2(CH_IN*K*K)-1:0]  wgt_addr,
  input  logic [WGT_W-1:0]              wgt_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_sat
);

  localparam int c_TAPS = K * K;
  localparam int c_NW   = CH_IN * K * K;
  localparam int c_AW   = $clog2(c_NW);
  localparam int c_CW   = (CH_IN > 1) ? $clog2(CH_IN) : 1;
  localparam int c_PW   = DATA_W + WGT_W;

  localparam logic [c_AW:0]              c_NW_V     = (c_AW + 1)'(c_NW);
  localparam logic [c_CW-1:0]            c_CH_LAST  = c_CW'(CH_IN - 1);
  localparam logic signed [ACC_W-1:0]    c_OMAX     = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0]    c_OMIN     = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  // ---------------------------------------------------------------- weights
  // No reset on the array: it is loaded by software before use.
  logic signed [WGT_W-1:0] r_wgt [c_NW];

  always_ff @(posedge clk) begin
    if (wgt_we && ({1'b0, wgt_addr} < c_NW_V)) begin
      r_wgt[wgt_addr] <= wgt_data;
    end
  end

  // ---------------------------------------------------------------- control
  logic            w_en;
  logic            w_accept;
  logic [c_CW-1:0] r_ch_cnt;

  // Whole pipeline freezes only while a finished result is blocked.
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;
  assign w_accept = in_valid && w_en && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_cnt <= '0;
    end else if (flush) begin
      r_ch_cnt <= '0;
    end else if (w_accept) begin
      r_ch_cnt <= (r_ch_cnt == c_CH_LAST) ? '0 : r_ch_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic signed [c_PW-1:0]  w_prod    [c_TAPS];
  logic signed [c_PW-1:0]  r_p1_prod [c_TAPS];
  logic                    r_p1_valid;
  logic                    r_p1_first;
  logic                    r_p1_last;
  logic signed [ACC_W-1:0] r_p1_bias;

  generate
    for (genvar t = 0; t < c_TAPS; t++) begin : g_tap
      logic [c_AW-1:0] w_waddr;
      assign w_waddr   = c_AW'(32'(r_ch_cnt) * c_TAPS + t);
      assign w_prod[t] = c_PW'($signed(in_data[t*DATA_W +: DATA_W])) * c_PW'(r_wgt[w_waddr]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1_valid <= 1'b0;
      r_p1_first <= 1'b0;
      r_p1_last  <= 1'b0;
      r_p1_bias  <= '0;
      for (int t = 0; t < c_TAPS; t++) begin
        r_p1_prod[t] <= '0;
      end
    end else if (flush) begin
      r_p1_valid <= 1'b0;
    end else if (w_en) begin
      r_p1_valid <= in_valid;
      if (in_valid) begin
        r_p1_first <= (r_ch_cnt == '0);
        r_p1_last  <= (r_ch_cnt == c_CH_LAST);
        r_p1_bias  <= bias;
        for (int t = 0; t < c_TAPS; t++) begin
          r_p1_prod[t] <= w_prod[t];
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  // The product tree is reduced in its own register stage so the accumulator
  // adder only sees two operands.
  logic signed [ACC_W-1:0] w_psum;
  logic signed [ACC_W-1:0] r_p2_sum;
  logic                    r_p2_valid;
  logic                    r_p2_first;
  logic                    r_p2_last;
  logic signed [ACC_W-1:0] r_p2_bias;

  always_comb begin
    w_psum = '0;
    for (int t = 0; t < c_TAPS; t++) begin
      w_psum = w_psum + ACC_W'(r_p1_prod[t]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p2_valid <= 1'b0;
      r_p2_first <= 1'b0;
      r_p2_last  <= 1'b0;
      r_p2_sum   <= '0;
      r_p2_bias  <= '0;
    end else if (flush) begin
      r_p2_valid <= 1'b0;
    end else if (w_en) begin
      r_p2_valid <= r_p1_valid;
      if (r_p1_valid) begin
        r_p2_first <= r_p1_first;
        r_p2_last  <= r_p1_last;
        r_p2_sum   <= w_psum;
        r_p2_bias  <= r_p1_bias;
      end
    end
  end

  // ---------------------------------------------------- accumulate / output
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_shift;
  logic [OUT_W-1:0]        w_res_data;
  logic                    w_res_sat;
  logic                    w_load;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_sat;

  // The first channel restarts from the bias instead of the running sum.
  assign w_acc_next = (r_p2_first ? r_p2_bias : r_acc) + r_p2_sum;
  assign w_shift    = w_acc_next >>> SHIFT;
  assign w_load     = w_en && !flush && r_p2_valid && r_p2_last;

  always_comb begin
    w_res_data = OUT_W'(w_shift);
    w_res_sat  = 1'b0;
    if ((RELU != 0) && w_shift[ACC_W-1]) begin
      w_res_data = '0;
    end else if (w_shift > c_OMAX) begin
      w_res_data = OUT_W'(c_OMAX);
      w_res_sat  = 1'b1;
    end else if (w_shift < c_OMIN) begin
      w_res_data = OUT_W'(c_OMIN);
      w_res_sat  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (flush) begin
      r_acc <= '0;
    end else if (w_en && r_p2_valid) begin
      r_acc <= w_acc_next;
    end
  end

  // A load on the same edge as a consume keeps valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_res_data;
      r_out_sat   <= w_res_sat;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_conv_chan_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_chan_mac
// Description : Self-checking bench for conv_chan_mac. A plain instance and a
//               RELU=1 instance share all inputs; a reference model computes
//               each expected result when its last beat is accepted and pushes
//               it to a scoreboard queue that output checks pop from.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_chan_mac;

  localparam int DATA_W = 12;
  localparam int WGT_W  = 8;
  localparam int K      = 3;
  localparam int CH_IN  = 3;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 14;
  localparam int NT     = K * K;
  localparam int NW     = CH_IN * K * K;

  logic                   clk       = 1'b0;
  logic                   rst_n     = 1'b0;
  logic                   flush     = 1'b0;
  logic                   in_valid  = 1'b0;
  logic                   out_ready = 1'b1;
  logic                   wgt_we    = 1'b0;
  logic [NT*DATA_W-1:0]   in_data   = '0;
  logic [ACC_W-1:0]       bias      = '0;
  logic [4:0]             wgt_addr  = '0;
  logic [WGT_W-1:0]       wgt_data  = '0;
  logic                   in_ready, out_valid, out_sat;
  logic                   in_ready_r, out_valid_r, out_sat_r;
  logic [OUT_W-1:0]       out_data, out_data_r;

  conv_chan_mac #(.RELU(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias(bias), .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  conv_chan_mac #(.RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .bias(bias), .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_sat(out_sat_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic signed [OUT_W-1:0] d;
    logic                    s;
    logic signed [OUT_W-1:0] dr;
    logic                    sr;
  } exp_t;

  exp_t   sbq[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint mw [NW];
  longint macc = 0;
  int     mch  = 0;

  function automatic exp_t make_exp(input longint a);
    exp_t   e;
    longint sh, mx, mn;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -mx - 1;
    sh = a >>> SHIFT;
    if (sh > mx) begin
      e.d = OUT_W'(mx); e.s = 1'b1;
    end else if (sh < mn) begin
      e.d = OUT_W'(mn); e.s = 1'b1;
    end else begin
      e.d = OUT_W'(sh); e.s = 1'b0;
    end
    if (sh < 0) begin
      e.dr = '0; e.sr = 1'b0;
    end else begin
      e.dr = e.d; e.sr = e.s;
    end
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    if (sbq.size() == 0) begin
      e.d = 'x; e.s = 1'bx; e.dr = 'x; e.sr = 1'bx;
    end else begin
      e = sbq.pop_front();
    end
    return e;
  endfunction

  // Presents one beat (taps base + t*step) starting at a negedge, waits for
  // acceptance, updates the model and returns on the following negedge with
  // in_valid still high. An optional weight write shares the accepting edge.
  task automatic send_beat(input int base, input int step, input int b,
                           input bit do_w = 1'b0, input int wa = 0, input int wd = 0);
    int     guard;
    longint s;
    for (int t = 0; t < NT; t++) in_data[t*DATA_W +: DATA_W] = DATA_W'(base + t * step);
    bias     = ACC_W'(b);
    in_valid = 1'b1;
    wgt_we   = do_w;
    wgt_addr = 5'(wa);
    wgt_data = WGT_W'(wd);
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end else begin
      s = 0;
      for (int t = 0; t < NT; t++) s += longint'(base + t * step) * mw[mch*NT + t];
      if (mch == 0) macc = longint'(b) + s;
      else          macc = macc + s;
      if (mch == CH_IN - 1) sbq.push_back(make_exp(macc));
      mch = (mch + 1) % CH_IN;
    end
    if (do_w && wa < NW) mw[wa] = longint'(wd);
    @(negedge clk);
    wgt_we = 1'b0;
  endtask

  task automatic load_weights(input bit pattern, input int v);
    int w;
    for (int i = 0; i < NW; i++) begin
      w        = pattern ? ((i * 7) % 11) - 5 : v;
      wgt_we   = 1'b1;
      wgt_addr = 5'(i);
      wgt_data = WGT_W'(w);
      mw[i]    = longint'(w);
      @(negedge clk);
    end
    wgt_we = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk); g++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_sat, out_data_r, out_sat_r} !== {1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d out_sat=%b relu_data=%0d, required 1 0 0 0 0",
               in_ready, out_valid, $signed(out_data), out_sat, $signed(out_data_r));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ones();
    exp_t e; bit ok;
    load_weights(1'b0, 1);
    repeat (3) send_beat(64, 0, 0);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_edge1: out_valid=%b required 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_edge2: out_valid=%b required 0", out_valid); end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_edge3: out_valid=%b required 1", out_valid); end
    e = pop_exp(); n_cmp++;
    if ({out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
      n_bad++;
      $display("FAIL ones_result: got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b",
               $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
    end
    wait_valid(ok);
    @(negedge clk);
  endtask

  task automatic test_saturate();
    exp_t e; bit ok;
    for (int k = 0; k < 2; k++) begin
      load_weights(1'b0, (k == 0) ? 127 : -128);
      repeat (3) send_beat(2047, 0, 0);
      in_valid = 1'b0;
      wait_valid(ok);
      e = pop_exp(); n_cmp++;
      if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
        n_bad++;
        $display("FAIL saturate_%0d: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", k, ok,
                 $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pattern();
    exp_t e; bit ok;
    load_weights(1'b1, 0);
    for (int k = 0; k < 2; k++) begin
      send_beat(100, 13, (k == 0) ? 1000 : -5000);
      send_beat(-200, 31, 7);
      send_beat(50, -9, 0);
      in_valid = 1'b0;
      wait_valid(ok);
      e = pop_exp(); n_cmp++;
      if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
        n_bad++;
        $display("FAIL pattern_%0d: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", k, ok,
                 $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int tstamp [2];
    fork
      begin
        repeat (3) send_beat(0, 0, 640);
        repeat (3) send_beat(64, -5, 640);
        in_valid = 1'b0;
      end
      begin
        exp_t e; bit ok;
        for (int i = 0; i < 2; i++) begin
          wait_valid(ok);
          tstamp[i] = cyc;
          e = pop_exp(); n_cmp++;
          if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
            n_bad++;
            $display("FAIL b2b_result_%0d: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", i, ok,
                     $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
          end
          @(negedge clk);
        end
      end
    join
    n_cmp++;
    if (tstamp[1] - tstamp[0] !== 3) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d clocks required 3", tstamp[1] - tstamp[0]);
    end
  endtask

  task automatic test_backpressure();
    fork
      begin
        send_beat(10, 3, 0);
        send_beat(-20, 5, 100);
        send_beat(30, -7, 0);
        send_beat(64, 1, -300);
        send_beat(-64, 9, 0);
        send_beat(5, 5, 0);
        in_valid = 1'b0;
      end
      begin
        exp_t e; bit ok; logic [OUT_W-1:0] held;
        wait_valid(ok);
        e = pop_exp(); n_cmp++;
        if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
          n_bad++;
          $display("FAIL bp_first: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", ok,
                   $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
        end
        held      = e.d;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          n_cmp++;
          if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, held}) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: valid=%b in_ready=%b data=%0d required 1 0 %0d",
                     i, out_valid, in_ready, $signed(out_data), $signed(held));
          end
        end
        out_ready = 1'b1;
        @(negedge clk);
        wait_valid(ok);
        e = pop_exp(); n_cmp++;
        if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
          n_bad++;
          $display("FAIL bp_second: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", ok,
                   $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
        end
        @(negedge clk);
      end
    join
  endtask

  task automatic test_flush();
    exp_t e; bit ok;
    load_weights(1'b0, 1);
    repeat (2) send_beat(64, 0, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b required 1", in_ready); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    mch      = 0;
    macc     = 0;
    repeat (3) send_beat(64, 0, 0);
    in_valid = 1'b0;
    wait_valid(ok);
    e = pop_exp(); n_cmp++;
    if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
      n_bad++;
      $display("FAIL flush_result: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", ok,
               $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
    end
    @(negedge clk);
  endtask

  task automatic test_weight_rewrite();
    exp_t e; bit ok;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) send_beat(64, 0, 0, 1'b1, 0, 2);
      else        send_beat(64, 0, 0);
      repeat (2) send_beat(64, 0, 0);
      in_valid = 1'b0;
      wait_valid(ok);
      e = pop_exp(); n_cmp++;
      if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
        n_bad++;
        $display("FAIL wgt_rewrite_%0d: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", k, ok,
                 $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok;
    out_ready = 1'b0;
    repeat (4) send_beat(64, 0, 0);
    in_valid = 1'b0;
    wait_valid(ok);
    n_cmp++;
    if ({ok, in_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL rst_pending: valid=%b in_ready=%b required 1 0", ok, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_sat, out_data_r, out_sat_r} !== {1'b1, 1'b0, 14'd0, 1'b0, 14'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid_state: in_ready=%b out_valid=%b out_data=%0d out_sat=%b relu_data=%0d, required 1 0 0 0 0",
               in_ready, out_valid, $signed(out_data), out_sat, $signed(out_data_r));
    end
    sbq.delete();
    mch  = 0;
    macc = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    repeat (3) send_beat(64, 0, 0);
    in_valid = 1'b0;
    wait_valid(ok);
    e = pop_exp(); n_cmp++;
    if (!ok || {out_data, out_sat, out_data_r, out_sat_r} !== {e.d, e.s, e.dr, e.sr}) begin
      n_bad++;
      $display("FAIL rst_restart: valid=%b got %0d/%b relu %0d/%b required %0d/%b relu %0d/%b", ok,
               $signed(out_data), out_sat, $signed(out_data_r), out_sat_r, e.d, e.s, e.dr, e.sr);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_ones();
    test_saturate();
    test_pattern();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_weight_rewrite();
    test_reset_mid();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (sbq.size() !== 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d out_valid=%b required 0 0", sbq.size(), out_valid);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
